// File: rtl/itlb_page_walker.sv
// Sv32 page-table walker behind the ITLB miss port: walks SATP-rooted tables, returns a refill PTE or a page fault.
// Latency: bare mode 1 cycle; a two-level walk takes 5 cycles with a ready read port and 1-cycle read latency.
// Backpressure: MEM_ARVALID/MEM_ARADDR held until MEM_ARREADY; one read outstanding; REQ_VALID dropped while busy.
module itlb_page_walker #(
    parameter int DATA_WIDTH        = 32,
    parameter int ADDR_WIDTH        = 32,
    parameter int PPN_LEN           = 22,
    parameter int VPN_LEN           = 10,
    parameter int PAGE_OFFSET_WIDTH = 12,
    parameter int PTESIZE           = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  SATP_MODE,
    input  logic [PPN_LEN-1:0]    SATP_PPN,
    input  logic                  FLUSH,
    input  logic                  REQ_VALID,
    input  logic [ADDR_WIDTH-1:0] REQ_VADDR,
    output logic                  BUSY,
    output logic                  MEM_ARVALID,
    output logic [ADDR_WIDTH-1:0] MEM_ARADDR,
    input  logic                  MEM_ARREADY,
    input  logic                  MEM_RVALID,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA,
    output logic                  RESP_VALID,
    output logic [DATA_WIDTH-1:0] RESP_PTE,
    output logic                  PAGE_FAULT,
    output logic [ADDR_WIDTH-1:0] FAULT_VADDR
);

    // Physical addresses are formed at PPN+offset width (34 bits) and truncated.
    localparam int PA_W = PPN_LEN + PAGE_OFFSET_WIDTH;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        L1_REQ  = 3'd1,
        L1_WAIT = 3'd2,
        L0_REQ  = 3'd3,
        L0_WAIT = 3'd4,
        DRAIN   = 3'd5
    } state_t;

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] vaddr;

    // PTE field decode of the returning read beat
    logic pte_v, pte_r, pte_w, pte_x, pte_a;
    assign pte_v = MEM_RDATA[0];
    assign pte_r = MEM_RDATA[1];
    assign pte_w = MEM_RDATA[2];
    assign pte_x = MEM_RDATA[3];
    assign pte_a = MEM_RDATA[6];

    logic [VPN_LEN-1:0] req_vpn1, vpn0;
    assign req_vpn1 = REQ_VADDR[ADDR_WIDTH-1 -: VPN_LEN];
    assign vpn0     = vaddr[PAGE_OFFSET_WIDTH +: VPN_LEN];

    logic [PA_W-1:0] root_addr, next_addr;
    assign root_addr = {SATP_PPN, {PAGE_OFFSET_WIDTH{1'b0}}} + PA_W'(req_vpn1) * PA_W'(PTESIZE);
    assign next_addr = {MEM_RDATA[DATA_WIDTH-1 -: PPN_LEN], {PAGE_OFFSET_WIDTH{1'b0}}}
                     + PA_W'(vpn0) * PA_W'(PTESIZE);

    // Reserved encoding (invalid or write-only) faults at either level.
    logic pte_bad, pte_ptr, l1_leaf_ok, l0_leaf_ok;
    assign pte_bad    = !pte_v || (!pte_r && pte_w);
    assign pte_ptr    = !pte_bad && !pte_r && !pte_x;
    // Superpage leaf must have zero PPN[0] to be aligned to 4 MiB.
    assign l1_leaf_ok = !pte_bad && !pte_ptr && (MEM_RDATA[19:10] == '0) && pte_x && pte_a;
    assign l0_leaf_ok = !pte_bad && !pte_ptr && pte_x && pte_a;

    logic start_walk;
    assign start_walk = (state == IDLE) && REQ_VALID && !FLUSH;

    // State register and captured miss address
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            vaddr <= '0;
        end else begin
            state <= next_state;
            if (start_walk) vaddr <= REQ_VADDR;
        end
    end

    // Next-state logic; flush either abandons an untransferred request or drains the one in flight
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_walk && SATP_MODE) next_state = L1_REQ;
            L1_REQ:  if (MEM_ARREADY)             next_state = FLUSH ? DRAIN : L1_WAIT;
                     else if (FLUSH)              next_state = IDLE;
            L0_REQ:  if (MEM_ARREADY)             next_state = FLUSH ? DRAIN : L0_WAIT;
                     else if (FLUSH)              next_state = IDLE;
            L1_WAIT: if (FLUSH)                   next_state = MEM_RVALID ? IDLE : DRAIN;
                     else if (MEM_RVALID)         next_state = pte_ptr ? L0_REQ : IDLE;
            L0_WAIT: if (FLUSH)                   next_state = MEM_RVALID ? IDLE : DRAIN;
                     else if (MEM_RVALID)         next_state = IDLE;
            DRAIN:   if (MEM_RVALID)              next_state = IDLE;
            default:                              next_state = IDLE;
        endcase
    end

    logic                  arvalid_d, resp_d, fault_d;
    logic [ADDR_WIDTH-1:0] araddr_d, fault_vaddr_d;
    logic [DATA_WIDTH-1:0] resp_pte_d;

    // Next values of the registered outputs; flush suppresses any response or fault
    always_comb begin
        arvalid_d     = (next_state == L1_REQ) || (next_state == L0_REQ);
        araddr_d      = MEM_ARADDR;
        resp_d        = 1'b0;
        resp_pte_d    = RESP_PTE;
        fault_d       = 1'b0;
        fault_vaddr_d = FAULT_VADDR;
        case (state)
            IDLE: begin
                if (start_walk && !SATP_MODE) begin
                    resp_d     = 1'b1;
                    resp_pte_d = {2'b00, REQ_VADDR[31:12], 10'h04B};
                end else if (start_walk) begin
                    araddr_d = root_addr[ADDR_WIDTH-1:0];
                end
            end
            L1_WAIT: begin
                if (!FLUSH && MEM_RVALID) begin
                    if (pte_ptr) begin
                        araddr_d = next_addr[ADDR_WIDTH-1:0];
                    end else if (l1_leaf_ok) begin
                        resp_d     = 1'b1;
                        resp_pte_d = {MEM_RDATA[31:20], vpn0, MEM_RDATA[9:0]};
                    end else begin
                        fault_d       = 1'b1;
                        fault_vaddr_d = vaddr;
                    end
                end
            end
            L0_WAIT: begin
                if (!FLUSH && MEM_RVALID) begin
                    if (l0_leaf_ok) begin
                        resp_d     = 1'b1;
                        resp_pte_d = MEM_RDATA;
                    end else begin
                        fault_d       = 1'b1;
                        fault_vaddr_d = vaddr;
                    end
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            BUSY        <= 1'b0;
            MEM_ARVALID <= 1'b0;
            MEM_ARADDR  <= '0;
            RESP_VALID  <= 1'b0;
            RESP_PTE    <= '0;
            PAGE_FAULT  <= 1'b0;
            FAULT_VADDR <= '0;
        end else begin
            BUSY        <= (next_state != IDLE);
            MEM_ARVALID <= arvalid_d;
            MEM_ARADDR  <= araddr_d;
            RESP_VALID  <= resp_d;
            RESP_PTE    <= resp_pte_d;
            PAGE_FAULT  <= fault_d;
            FAULT_VADDR <= fault_vaddr_d;
        end
    end

endmodule

// File: tb/tb_itlb_page_walker.sv
// Directed bench for itlb_page_walker: stimulus pushes expected refills/faults to a scoreboard,
// a negedge monitor pops and compares them, and a memory responder checks PTE read addresses.
module tb_itlb_page_walker;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        SATP_MODE = 1'b0;
    logic [21:0] SATP_PPN = '0;
    logic        FLUSH = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic [31:0] REQ_VADDR = '0;
    logic        BUSY;
    logic        MEM_ARVALID;
    logic [31:0] MEM_ARADDR;
    logic        MEM_ARREADY = 1'b1;
    logic        MEM_RVALID = 1'b0;
    logic [31:0] MEM_RDATA = '0;
    logic        RESP_VALID;
    logic [31:0] RESP_PTE;
    logic        PAGE_FAULT;
    logic [31:0] FAULT_VADDR;

    itlb_page_walker dut (
        .CLK(CLK), .RST_N(RST_N), .SATP_MODE(SATP_MODE), .SATP_PPN(SATP_PPN),
        .FLUSH(FLUSH), .REQ_VALID(REQ_VALID), .REQ_VADDR(REQ_VADDR), .BUSY(BUSY),
        .MEM_ARVALID(MEM_ARVALID), .MEM_ARADDR(MEM_ARADDR), .MEM_ARREADY(MEM_ARREADY),
        .MEM_RVALID(MEM_RVALID), .MEM_RDATA(MEM_RDATA), .RESP_VALID(RESP_VALID),
        .RESP_PTE(RESP_PTE), .PAGE_FAULT(PAGE_FAULT), .FAULT_VADDR(FAULT_VADDR)
    );

    typedef struct {
        logic        is_fault;
        logic [31:0] val;
        int          cyc;      // required output cycle, -1 = any
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } mem_t;

    exp_t exp_q[$];
    mem_t mem_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int xfers = 0;
    int mem_lat = 1;
    int rcnt = 0;
    logic [31:0] rdat = '0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input logic is_fault, input logic [31:0] val, input int c);
        exp_t e;
        e.is_fault = is_fault;
        e.val = val;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic push_mem(input logic [31:0] addr, input logic [31:0] data);
        mem_t m;
        m.addr = addr;
        m.data = data;
        mem_q.push_back(m);
    endtask

    // Called at posedge+1; REQ_VALID is high for the current cycle only.
    task automatic send_req(input logic [31:0] va);
        REQ_VALID = 1'b1;
        REQ_VADDR = va;
        tick();
        REQ_VALID = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || BUSY) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL wait_done: timeout, %0d responses still pending, busy=%b", exp_q.size(), BUSY);
            exp_q.delete();
        end
        tick();
        tick();
    endtask

    // Memory responder: accepts a read on the ARVALID&ARREADY cycle, returns data mem_lat cycles later.
    initial begin
        forever begin
            @(negedge CLK);
            if (RST_N && MEM_ARVALID && MEM_ARREADY) begin
                xfers++;
                if (mem_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mem_read: unexpected read addr %h", MEM_ARADDR);
                    rdat = '0;
                end else begin
                    mem_t m;
                    m = mem_q.pop_front();
                    chk("mem_araddr", MEM_ARADDR, m.addr);
                    rdat = m.data;
                end
                rcnt = mem_lat;
            end
        end
    end

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            MEM_RVALID = 1'b0;
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    MEM_RVALID = 1'b1;
                    MEM_RDATA = rdat;
                end
            end
        end
    end

    // Output monitor: every refill or fault pulse must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge CLK);
            if (RESP_VALID || PAGE_FAULT) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: resp=%b pte=%h fault=%b vaddr=%h",
                             RESP_VALID, RESP_PTE, PAGE_FAULT, FAULT_VADDR);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_is_fault", {31'b0, PAGE_FAULT}, {31'b0, e.is_fault});
                    chk("out_is_resp", {31'b0, RESP_VALID}, {31'b0, !e.is_fault});
                    if (e.is_fault) chk("fault_vaddr", FAULT_VADDR, e.val);
                    else            chk("resp_pte", RESP_PTE, e.val);
                    if (e.cyc >= 0) chk("out_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        int c0;
        int x0;
        RST_N = 1'b1;
        #1 RST_N = 1'b0;
        #2;
        chk("rst_busy", {31'b0, BUSY}, 32'd0);
        chk("rst_arvalid", {31'b0, MEM_ARVALID}, 32'd0);
        chk("rst_araddr", MEM_ARADDR, 32'd0);
        chk("rst_resp_valid", {31'b0, RESP_VALID}, 32'd0);
        chk("rst_resp_pte", RESP_PTE, 32'd0);
        chk("rst_page_fault", {31'b0, PAGE_FAULT}, 32'd0);
        chk("rst_fault_vaddr", FAULT_VADDR, 32'd0);
        tick();
        tick();
        RST_N = 1'b1;
        tick();

        // Bare mode: identity PTE one cycle later, no memory traffic
        SATP_MODE = 1'b0;
        x0 = xfers;
        c0 = cyc;
        push_exp(1'b0, 32'h0010_044B, c0 + 1);
        send_req(32'h0040_1123);
        wait_done();
        chk("bare_no_read", 32'(xfers), 32'(x0));

        // Two-level walk with full latency check
        SATP_MODE = 1'b1;
        SATP_PPN = 22'h3E8;
        push_mem(32'h003E_8004, 32'h0010_0001);
        push_mem(32'h0040_0004, 32'h048D_144B);
        c0 = cyc;
        push_exp(1'b0, 32'h048D_144B, c0 + 5);
        send_req(32'h0040_1123);
        wait_done();

        // Superpage leaf: PPN[0] replaced by vpn0
        push_mem(32'h003E_8008, 32'h0030_004B);
        c0 = cyc;
        push_exp(1'b0, 32'h0030_084B, c0 + 3);
        send_req(32'h0080_2000);
        wait_done();

        // Misaligned superpage
        push_mem(32'h003E_8008, 32'h0030_044B);
        c0 = cyc;
        push_exp(1'b1, 32'h0080_2000, c0 + 3);
        send_req(32'h0080_2000);
        wait_done();

        // Invalid L1 PTE
        push_mem(32'h003E_8004, 32'h0000_0000);
        push_exp(1'b1, 32'h0040_1123, -1);
        send_req(32'h0040_1123);
        wait_done();

        // L0 leaf with A=0
        push_mem(32'h003E_8004, 32'h0010_0001);
        push_mem(32'h0040_0004, 32'h048D_140B);
        c0 = cyc;
        push_exp(1'b1, 32'h0040_1123, c0 + 5);
        send_req(32'h0040_1123);
        wait_done();

        // REQ_VALID together with FLUSH in IDLE is dropped
        x0 = xfers;
        FLUSH = 1'b1;
        send_req(32'h0040_1123);
        FLUSH = 1'b0;
        tick();
        tick();
        chk("req_flush_busy", {31'b0, BUSY}, 32'd0);
        chk("req_flush_no_read", 32'(xfers), 32'(x0));

        // Back-pressure: request held stable for 4 stalled cycles, one transfer
        x0 = xfers;
        MEM_ARREADY = 1'b0;
        push_mem(32'h003E_8008, 32'h0030_004B);
        push_exp(1'b0, 32'h0030_084B, -1);
        send_req(32'h0080_2000);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("bp_arvalid", {31'b0, MEM_ARVALID}, 32'd1);
            chk("bp_araddr", MEM_ARADDR, 32'h003E_8008);
            tick();
        end
        MEM_ARREADY = 1'b1;
        wait_done();
        chk("bp_one_xfer", 32'(xfers), 32'(x0 + 1));

        // FLUSH in L1_WAIT with a slow read: beat drained, nothing reported
        mem_lat = 4;
        push_mem(32'h003E_8008, 32'h0030_004B);
        send_req(32'h0080_2000);   // now in cycle c0+1 (L1 request accepted)
        tick();                    // c0+2: L1_WAIT
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;              // c0+3
        for (int k = 3; k <= 6; k++) begin
            @(negedge CLK);
            chk("flush_busy", {31'b0, BUSY}, (k <= 5) ? 32'd1 : 32'd0);
            tick();
        end
        mem_lat = 1;
        tick();

        // A fresh walk after the flush completes normally
        push_mem(32'h003E_8004, 32'h0010_0001);
        push_mem(32'h0040_0004, 32'h048D_144B);
        c0 = cyc;
        push_exp(1'b0, 32'h048D_144B, c0 + 5);
        send_req(32'h0040_1123);
        wait_done();

        // Reset in L0_WAIT: outputs clear at once, late beat ignored
        mem_lat = 3;
        push_mem(32'h003E_8004, 32'h0010_0001);
        push_mem(32'h0040_0004, 32'h048D_144B);
        send_req(32'h0040_1123);   // c0+1
        for (int i = 0; i < 5; i++) tick();   // c0+6: L0_WAIT
        chk("l0wait_busy", {31'b0, BUSY}, 32'd1);
        RST_N = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, BUSY}, 32'd0);
        chk("midrst_arvalid", {31'b0, MEM_ARVALID}, 32'd0);
        chk("midrst_resp_valid", {31'b0, RESP_VALID}, 32'd0);
        chk("midrst_page_fault", {31'b0, PAGE_FAULT}, 32'd0);
        tick();
        RST_N = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("postrst_busy", {31'b0, BUSY}, 32'd0);
        mem_lat = 1;

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("mem_queue_empty", 32'(mem_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
